// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32-M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide behind a valid/ready handshake.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    FIX,
    FAST,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]  f3_q;
  logic        sa_q, sb_q;
  logic [31:0] hi_q, lo_q, mag_q;
  logic [4:0]  cnt_q;

  logic        accept;
  logic        a_sgn, b_sgn;
  logic [31:0] a_abs, b_abs;
  logic        div_zero, div_ovf, is_fast;
  logic [31:0] fast_res;

  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;

  logic [63:0] prod, prod_s;
  logic [31:0] q_s, r_s, fix_res;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && !kill;

  assign a_sgn = a[31] &&
    (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
  assign b_sgn = b[31] &&
    (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
  assign a_abs = a_sgn ? -a : a;
  assign b_abs = b_sgn ? -b : b;

  assign div_zero = funct3[2] && (b == 32'd0);
  assign div_ovf  = funct3[2] && !funct3[0] &&
    (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign is_fast  = div_zero || div_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    fast_res = 32'd0;
    unique case (1'b1)
      div_zero && !funct3[1]: fast_res = 32'hFFFF_FFFF;
      div_zero &&  funct3[1]: fast_res = a;
      div_ovf  && !funct3[1]: fast_res = 32'h8000_0000;
      default:                fast_res = 32'd0;
    endcase
  end

  // multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0]
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : 33'd0);

  // divide: remainder in hi, dividend shifts out of lo as quotient shifts in
  assign div_sh = {hi_q, lo_q[31]};
  assign div_ge = div_sh >= {1'b0, mag_q};

  assign prod    = {hi_q, lo_q};
  assign prod_s  = (sa_q ^ sb_q) ? -prod : prod;
  assign q_s     = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign r_s     = sa_q ? -hi_q : hi_q;
  assign fix_res = f3_q[2] ? (f3_q[1] ? r_s : q_s)
                 : ((f3_q[1:0] == 2'b00) ? prod_s[31:0]
                                         : prod_s[63:32]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = is_fast ? FAST : CALC;
      CALC: begin
        if (kill)                state_nx = IDLE;
        else if (cnt_q == 5'd31) state_nx = FIX;
      end
      FIX:  state_nx = kill ? IDLE : DONE;
      FAST: state_nx = kill ? IDLE : DONE;
      DONE: begin
        if (kill || (resp_valid && resp_ready)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q       <= 3'd0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      mag_q      <= 32'd0;
      cnt_q      <= 5'd0;
      result     <= 32'd0;
      resp_valid <= 1'b0;
    end else begin
      // response rises one edge after DONE entry, drops on leaving
      resp_valid <= (state == DONE) && (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            f3_q  <= funct3;
            sa_q  <= a_sgn;
            sb_q  <= b_sgn;
            cnt_q <= 5'd0;
            hi_q  <= 32'd0;
            if (is_fast) begin
              lo_q  <= fast_res;
              mag_q <= 32'd0;
            end else if (funct3[2]) begin
              lo_q  <= a_abs;
              mag_q <= b_abs;
            end else begin
              lo_q  <= b_abs;
              mag_q <= a_abs;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (f3_q[2]) begin
            hi_q <= div_ge ? (div_sh[31:0] - mag_q) : div_sh[31:0];
            lo_q <= {lo_q[30:0], div_ge};
          end else begin
            hi_q <= mul_sum[32:1];
            lo_q <= {mul_sum[0], lo_q[31:1]};
          end
        end
        FIX:  if (!kill) result <= fix_res;
        FAST: if (!kill) result <= lo_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq
// against a plain-arithmetic RV32-M reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a, b;
  logic [2:0]  funct3;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res;
  logic        exp_live;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .funct3     (funct3),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result)
  );

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] xs, ys, p;
    logic        ovf;
    logic [31:0] r;
    xs  = (f inside {3'd0, 3'd1, 3'd2}) ? {{32{x[31]}}, x} : {32'd0, x};
    ys  = (f inside {3'd0, 3'd1}) ? {{32{y[31]}}, y} : {32'd0, y};
    p   = xs * ys;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r   = 32'd0;
    case (f)
      3'd0: r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      3'd4: begin
        if (y == 32'd0) r = 32'hFFFF_FFFF;
        else if (ovf)   r = 32'h8000_0000;
        else            r = $signed(x) / $signed(y);
      end
      3'd5: begin
        if (y == 32'd0) r = 32'hFFFF_FFFF;
        else            r = x / y;
      end
      3'd6: begin
        if (y == 32'd0) r = x;
        else if (ovf)   r = 32'd0;
        else            r = $signed(x) % $signed(y);
      end
      default: begin
        if (y == 32'd0) r = x;
        else            r = x % y;
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // every cycle with a response, it must be the expected one
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      checks++;
      if (!exp_live || result !== exp_res) begin
        errors++;
        $display("FAIL resp: got %h expected %h live=%0b",
                 result, exp_res, exp_live);
      end
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input int bp,
                       output logic [31:0] res);
    int  n;
    int  lat;
    logic busy_bad;
    logic fast;
    fast = f[2] && ((y == 32'd0) ||
           (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    lat  = fast ? 2 : 34;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    funct3    = f;
    a         = x;
    b         = y;
    exp_res   = model(f, x, y);
    exp_live  = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    a         = $urandom;
    b         = $urandom;
    funct3    = 3'($urandom);
    n         = 0;
    busy_bad  = 1'b0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1; n++;
      if (req_ready) busy_bad = 1'b1;
    end
    chk("latency", n, lat);
    chk("busy_ready", {31'd0, busy_bad}, 32'd0);
    res = result;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_live   = 1'b0;
    chk("hs_valid", {31'd0, resp_valid}, 32'd0);
    chk("hs_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic directed(input string nm, input logic [2:0] f,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] want);
    logic [31:0] r;
    do_op(f, x, y, 0, r);
    chk(nm, r, want);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    funct3     = 3'd0;
    kill       = 1'b0;
    resp_ready = 1'b0;
    exp_res    = 32'd0;
    exp_live   = 1'b0;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    directed("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    directed("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    directed("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    directed("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    directed("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    directed("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    directed("divu", 3'd5, 32'd7, 32'd2, 32'd3);
    directed("remu", 3'd7, 32'd7, 32'd2, 32'd1);
    directed("div_z", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    directed("rem_z", 3'd6, 32'd5, 32'd0, 32'd5);
    directed("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    directed("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    directed("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    do_op(3'd5, 32'd1000, 32'd9, 5, r);
    chk("bp_result", r, 32'd111);

    // kill in IDLE blocks the accept
    req_valid = 1'b1;
    kill      = 1'b1;
    a         = 32'd1;
    b         = 32'd1;
    funct3    = 3'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    kill      = 1'b0;
    chk("kill_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("kill_idle2", {31'd0, req_ready}, 32'd1);

    // kill at iteration 10
    req_valid = 1'b1;
    funct3    = 3'd0;
    a         = 32'd123;
    b         = 32'd456;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_ready", {31'd0, req_ready}, 32'd1);
    chk("kill_valid", {31'd0, resp_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1 chk("kill_quiet", {31'd0, resp_valid}, 32'd0);
    directed("after_kill", 3'd5, 32'd100, 32'd7, 32'd14);

    // asynchronous reset during CALC
    req_valid = 1'b1;
    funct3    = 3'd3;
    a         = 32'hDEAD_BEEF;
    b         = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed("after_rst", 3'd0, 32'd3, 32'd4, 32'd12);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(),
            int'($urandom_range(0, 3)), r);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
